// File: rtl/gnss_sample_unpacker.sv
// rtl/gnss_sample_unpacker.sv - byte FIFO feeding a 2-bit IF sample unpacker with rate strobe
// Emits one sample per rate strobe and counts strobes that find no sample ready.
module gnss_sample_unpacker #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int CNT_W      = 16,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             enable,
  input  logic             cfg_packed,
  input  logic [DIV_W-1:0] cfg_rate_div,
  output logic [1:0]       data_out,
  output logic             data_out_valid,
  output logic [LVL_W-1:0] fifo_level,
  output logic [CNT_W-1:0] underrun_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       rem_q, rem_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [1:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] underrun_q, underrun_d;

  logic             push, pop, strobe, emit, fifo_empty;
  logic [DIV_W-1:0] cnt_base;
  logic [2:0]       rem_after;
  logic [7:0]       shift_after;

  assign s_axis_tready = aresetn && (level_q < LVL_W'(FIFO_DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign fifo_empty    = (level_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    shift_d     = shift_q;
    rem_d       = rem_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    underrun_d  = underrun_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;

    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counter restarts from zero on every IDLE->RUN entry.
    cnt_base = (state_q == RUN) ? cnt_q : '0;
    strobe   = enable && (cnt_base == cfg_rate_div);
    if (enable && !strobe) cnt_d = cnt_base + 1'b1;

    emit        = strobe && (rem_q != 3'd0);
    rem_after   = emit ? rem_q - 3'd1 : rem_q;
    shift_after = emit ? {2'b00, shift_q[7:2]} : shift_q;

    // Reloading on the same cycle the last sample leaves keeps back-to-back output.
    pop = enable && (rem_after == 3'd0) && !fifo_empty;
    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
      rem_d    = cfg_packed ? 3'd4 : 3'd1;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      shift_d  = shift_after;
      rem_d    = rem_after;
    end

    if (emit) begin
      data_d  = shift_q[1:0];
      valid_d = 1'b1;
    end
    if (strobe && (rem_q == 3'd0) && (underrun_q != '1)) underrun_d = underrun_q + 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shift_q    <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      shift_q    <= shift_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
    end
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign fifo_level     = level_q;
  assign underrun_cnt   = underrun_q;

endmodule

// File: tb/tb_gnss_sample_unpacker.sv
// tb/tb_gnss_sample_unpacker.sv - directed scoreboard bench for gnss_sample_unpacker
module tb_gnss_sample_unpacker;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        enable = 1'b0;
  logic        cfg_packed = 1'b0;
  logic [15:0] cfg_rate_div = 16'd0;
  logic [1:0]  data_out;
  logic        data_out_valid;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_cnt;

  gnss_sample_unpacker #(.FIFO_DEPTH(16), .DIV_W(16), .CNT_W(16)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .enable         (enable),
    .cfg_packed     (cfg_packed),
    .cfg_rate_div   (cfg_rate_div),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .fifo_level     (fifo_level),
    .underrun_cnt   (underrun_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] sb[$];
  int         vq[$];

  always @(negedge aclk) begin
    if (aresetn && data_out_valid) begin
      vq.push_back(cyc);
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $error("FAIL sample_unexpected: observed %0d, none expected", data_out);
      end else begin
        automatic logic [1:0] exp = sb.pop_front();
        assert (data_out === exp) else begin
          fails++;
          $error("FAIL sample: observed %0d expected %0d", data_out, exp);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, output int acc);
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (s_axis_tready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge aclk);
    end
    if (acc < 0) begin
      check("push_timeout", 32'd1, 32'd0);
      s_axis_tvalid = 1'b0;
      return;
    end
    if (cfg_packed) begin
      for (int k = 0; k < 4; k++) sb.push_back(b[2*k +: 2]);
    end else begin
      sb.push_back(b[1:0]);
    end
    @(posedge aclk);
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500; i++) begin
      if (sb.size() == 0) break;
      @(negedge aclk);
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_spacing(input string tag, input int n, input int gap);
    check({tag, "_count"}, vq.size(), n);
    for (int i = 1; i < vq.size(); i++) check({tag, "_gap"}, vq[i] - vq[i-1], gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, first, st;

    #1;
    check("rst_tready", s_axis_tready, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun_cnt, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_tready", s_axis_tready, 1);

    // Unpacked, rate divider 0: one sample per byte, first sample two edges after accept.
    @(negedge aclk);
    cfg_rate_div = 16'd0;
    cfg_packed   = 1'b0;
    enable       = 1'b1;
    vq.delete();
    push_byte(8'h03, first);
    push_byte(8'hFE, acc);
    push_byte(8'h01, acc);
    push_byte(8'h42, acc);
    wait_drain();
    check_spacing("t2", 4, 1);
    check("t2_latency", vq[0], first + 2);

    // Packed: four samples per byte LSB pair first, next byte without a bubble.
    repeat (3) @(negedge aclk);
    cfg_packed = 1'b1;
    vq.delete();
    push_byte(8'hE4, first);
    push_byte(8'h1B, acc);
    wait_drain();
    check_spacing("t3", 8, 1);
    check("t3_latency", vq[0], first + 2);

    // Rate divider 3 on preloaded bytes.
    repeat (3) @(negedge aclk);
    enable       = 1'b0;
    cfg_packed   = 1'b0;
    cfg_rate_div = 16'd3;
    for (int i = 0; i < 8; i++) push_byte(8'(i * 29 + 3), acc);
    repeat (3) @(negedge aclk);
    vq.delete();
    st     = cyc;
    enable = 1'b1;
    wait_drain();
    repeat (8) @(negedge aclk);
    check_spacing("t4", 8, 4);
    check("t4_first", vq[0], st + 4);
    enable = 1'b0;

    // Asynchronous reset in the middle of a packed byte.
    @(negedge aclk);
    cfg_rate_div = 16'd0;
    cfg_packed   = 1'b1;
    push_byte(8'hAA, acc);
    push_byte(8'h55, acc);
    enable = 1'b1;
    @(posedge aclk);
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("t1_valid", data_out_valid, 0);
    check("t1_data", data_out, 0);
    check("t1_level", fifo_level, 0);
    check("t1_underrun", underrun_cnt, 0);
    check("t1_tready", s_axis_tready, 0);
    sb.delete();
    enable = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("t1_rel_level", fifo_level, 0);
    check("t1_rel_underrun", underrun_cnt, 0);
    check("t1_rel_tready", s_axis_tready, 1);

    // Underrun: two samples, then ten empty strobes at divider 1.
    cfg_rate_div = 16'd1;
    cfg_packed   = 1'b0;
    push_byte(8'h02, acc);
    push_byte(8'h01, acc);
    repeat (3) @(negedge aclk);
    vq.delete();
    enable = 1'b1;
    repeat (24) @(negedge aclk);
    enable = 1'b0;
    @(negedge aclk);
    check_spacing("t5", 2, 2);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_underrun", underrun_cnt, 10);
    check("t5_valid", data_out_valid, 0);

    // Backpressure: FIFO fills at 16 while held, then drains all 20 in order.
    cfg_rate_div = 16'd0;
    vq.delete();
    for (int i = 0; i < 16; i++) push_byte(8'(i * 37 + 5), acc);
    check("t6_level_full", fifo_level, 16);
    check("t6_tready_full", s_axis_tready, 0);
    s_axis_tdata  = 8'(16 * 37 + 5);
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge aclk);
    check("t6_level_hold", fifo_level, 16);
    check("t6_tready_hold", s_axis_tready, 0);
    enable = 1'b1;
    for (int i = 16; i < 20; i++) push_byte(8'(i * 37 + 5), acc);
    wait_drain();
    check("t6_count", vq.size(), 20);
    check("t6_level_empty", fifo_level, 0);
    enable = 1'b0;

    @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
